hermitian_bram_writer: RTL and testbench

//  Write-side counterpart of the Hermitian read path. Accepts a row-major stream of complex

---
 rtl/hermitian_bram_writer_if.sv | 28 ++
 rtl/hermitian_bram_writer.sv | 129 ++++++++++++
 tb/tb_hermitian_bram_writer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hermitian_bram_writer_if.sv
// Stream-in / BRAM-write bundle for the Hermitian writer.
// master drives the element stream and start; slave is the writer itself.
interface hermitian_bram_writer_if #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] real_in;
    logic [DATA_WIDTH-1:0] imag_in;
    logic                  bram_wr_en;
    logic [ADDR_WIDTH-1:0] bram_wr_addr;
    logic [DATA_WIDTH-1:0] bram_wr_real;
    logic [DATA_WIDTH-1:0] bram_wr_imag;
    logic                  busy;
    logic                  done;

    modport master (
        output start, in_valid, real_in, imag_in,
        input  in_ready, bram_wr_en, bram_wr_addr, bram_wr_real, bram_wr_imag, busy, done
    );

    modport slave (
        input  start, in_valid, real_in, imag_in,
        output in_ready, bram_wr_en, bram_wr_addr, bram_wr_real, bram_wr_imag, busy, done
    );
endinterface

// File: rtl/hermitian_bram_writer.sv
// Takes a row-major ROWS x COLS complex matrix stream and writes its (conjugate)
// transpose column-major into BRAM: A[r][c] lands at address c*ROWS + r.
module hermitian_bram_writer #(
    parameter int unsigned DATA_WIDTH         = 24,
    parameter int unsigned BRAM_WR_ADDR_WIDTH = 10,
    parameter int unsigned ROWS               = 4,
    parameter int unsigned COLS               = 4,
    parameter bit          CONJ               = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    hermitian_bram_writer_if.slave        bus
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = BRAM_WR_ADDR_WIDTH;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] addr_cnt_q, addr_cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_real_q, wr_real_d;
    logic [DW-1:0] wr_imag_q, wr_imag_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          accept;
    logic [DW-1:0] imag_xfm;

    assign bus.in_ready = (state_q == S_RUN);
    assign accept       = bus.in_valid && (state_q == S_RUN);

    // Conjugation with saturation: the most negative value has no positive twin.
    always_comb begin
        imag_xfm = bus.imag_in;
        if (CONJ) begin
            if (bus.imag_in == NEG_MIN) imag_xfm = POS_MAX;
            else                        imag_xfm = DW'(0) - bus.imag_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        addr_cnt_d = addr_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_real_d  = wr_real_q;
        wr_imag_d  = wr_imag_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_RUN;
                    row_d      = '0;
                    col_d      = '0;
                    addr_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_cnt_q;
                    wr_real_d = bus.real_in;
                    wr_imag_d = imag_xfm;
                    // Column stride is ROWS; a row wrap restarts at the next row's base.
                    if (col_q == CW'(COLS - 1)) begin
                        col_d      = '0;
                        row_d      = row_q + RW'(1);
                        addr_cnt_d = AW'(row_q) + AW'(1);
                        if (row_q == RW'(ROWS - 1)) begin
                            state_d    = S_DONE;
                            row_d      = '0;
                            addr_cnt_d = '0;
                        end
                    end else begin
                        col_d      = col_q + CW'(1);
                        addr_cnt_d = addr_cnt_q + AW'(ROWS);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            addr_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_real_q  <= '0;
            wr_imag_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_cnt_q <= addr_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_real_q  <= wr_real_d;
            wr_imag_q  <= wr_imag_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.bram_wr_en   = wr_en_q;
    assign bus.bram_wr_addr = wr_addr_q;
    assign bus.bram_wr_real = wr_real_q;
    assign bus.bram_wr_imag = wr_imag_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_hermitian_bram_writer.sv
// Directed bench: a CONJ=1 writer and a CONJ=0 twin share one stimulus stream.
module tb_hermitian_bram_writer;
    localparam int unsigned DW   = 24;
    localparam int unsigned AW   = 10;
    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 2;
    localparam int          N    = ROWS * COLS;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hermitian_bram_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
    hermitian_bram_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

    assign b1.start    = b0.start;
    assign b1.in_valid = b0.in_valid;
    assign b1.real_in  = b0.real_in;
    assign b1.imag_in  = b0.imag_in;

    hermitian_bram_writer #(.DATA_WIDTH(DW), .BRAM_WR_ADDR_WIDTH(AW), .ROWS(ROWS),
                            .COLS(COLS), .CONJ(1'b1)) u_conj (.clk(clk), .rst(rst), .bus(b0));
    hermitian_bram_writer #(.DATA_WIDTH(DW), .BRAM_WR_ADDR_WIDTH(AW), .ROWS(ROWS),
                            .COLS(COLS), .CONJ(1'b0)) u_plain (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Element k in row-major order: A[r][c] = (10r+c) + j(100r+c), with two
    // saturation probes replacing the imag part of the first two elements.
    function automatic logic [DW-1:0] el_re(input int k);
        return DW'(10 * (k / COLS) + (k % COLS));
    endfunction

    function automatic logic [DW-1:0] el_im(input int k, input bit sat);
        if (sat && k == 0) return 24'h800000;
        if (sat && k == 1) return 24'h000001;
        return DW'(100 * (k / COLS) + (k % COLS));
    endfunction

    function automatic logic [DW-1:0] exp_im(input int k, input bit sat);
        if (sat && k == 0) return 24'h7FFFFF;
        if (sat && k == 1) return 24'hFFFFFF;
        return DW'(-(100 * (k / COLS) + (k % COLS)));
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first RUN cycle.
    task automatic do_start(input bit hold);
        b0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) b0.start = 1'b0;
        chk("busy_after_start", 32'(b0.busy), 32'd1);
    endtask

    // Streams one matrix and checks every output cycle; returns at the DONE-cycle negedge.
    task automatic stream(input bit bubbles, input bit sat);
        int k = 0;
        int pk = -1;
        int cyc = 0;
        bit tog = 1'b1;
        bit offer, rdy;
        forever begin
            if (pk >= 0) begin
                chk("wr_en", 32'(b0.bram_wr_en), 32'd1);
                chk("wr_addr", 32'(b0.bram_wr_addr), 32'((pk % COLS) * ROWS + pk / COLS));
                chk("wr_real", 32'(b0.bram_wr_real), 32'(el_re(pk)));
                chk("wr_imag_conj", 32'(b0.bram_wr_imag), 32'(exp_im(pk, sat)));
                chk("wr_imag_plain", 32'(b1.bram_wr_imag), 32'(el_im(pk, sat)));
                chk("done", 32'(b0.done), 32'(pk == N - 1));
                chk("busy_run", 32'(b0.busy), 32'd1);
            end else begin
                chk("wr_en_gap", 32'(b0.bram_wr_en), 32'd0);
                chk("done_gap", 32'(b0.done), 32'd0);
            end
            if (pk == N - 1) break;
            if (cyc > 200) begin
                total++;
                bad++;
                $error("FAIL stream_timeout observed=%0d cycles expected<=200", cyc);
                break;
            end
            offer = (k < N) && (!bubbles || tog);
            tog = !tog;
            b0.in_valid = offer;
            b0.real_in  = el_re(k);
            b0.imag_in  = el_im(k, sat);
            rdy = b0.in_ready;
            chk("in_ready_run", 32'(rdy), 32'd1);
            @(posedge clk);
            if (offer && rdy) begin
                pk = k;
                k++;
            end else begin
                pk = -1;
            end
            @(negedge clk);
            cyc++;
        end
        b0.in_valid = 1'b0;
        chk("in_ready_done", 32'(b0.in_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        b0.start = 1'b0;
        b0.in_valid = 1'b0;
        b0.real_in = '0;
        b0.imag_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(b0.bram_wr_en), 32'd0);
        chk("rst_addr", 32'(b0.bram_wr_addr), 32'd0);
        chk("rst_real", 32'(b0.bram_wr_real), 32'd0);
        chk("rst_imag", 32'(b0.bram_wr_imag), 32'd0);
        chk("rst_done", 32'(b0.done), 32'd0);
        chk("rst_busy", 32'(b0.busy), 32'd0);
        chk("rst_in_ready", 32'(b0.in_ready), 32'd0);
        rst = 1'b0;

        // Elements offered in IDLE are never written.
        b0.in_valid = 1'b1;
        b0.real_in = 24'd5;
        b0.imag_in = 24'd7;
        @(negedge clk);
        chk("idle_in_ready", 32'(b0.in_ready), 32'd0);
        chk("idle_wr_en", 32'(b0.bram_wr_en), 32'd0);
        @(negedge clk);
        chk("idle_wr_en2", 32'(b0.bram_wr_en), 32'd0);
        b0.in_valid = 1'b0;

        // Basic stream, then back-to-back start in the cycle after done.
        do_start(1'b0);
        stream(1'b0, 1'b0);
        @(negedge clk);
        chk("post_done_busy", 32'(b0.busy), 32'd0);
        chk("post_done_wr_en", 32'(b0.bram_wr_en), 32'd0);
        do_start(1'b0);
        stream(1'b0, 1'b0);
        @(negedge clk);

        // Bubbles on in_valid.
        do_start(1'b0);
        stream(1'b1, 1'b0);
        @(negedge clk);

        // Saturating conjugation probes.
        do_start(1'b0);
        stream(1'b0, 1'b1);
        @(negedge clk);

        // start held through RUN and the DONE cycle must not restart.
        do_start(1'b1);
        stream(1'b0, 1'b0);
        @(negedge clk);
        chk("no_restart_busy", 32'(b0.busy), 32'd0);
        chk("no_restart_ready", 32'(b0.in_ready), 32'd0);
        b0.start = 1'b0;
        @(negedge clk);
        chk("no_restart_busy2", 32'(b0.busy), 32'd0);
        chk("no_restart_wr_en", 32'(b0.bram_wr_en), 32'd0);

        // Reset after three accepts, then a fresh full matrix.
        do_start(1'b0);
        for (int k = 0; k < 3; k++) begin
            b0.in_valid = 1'b1;
            b0.real_in  = el_re(k);
            b0.imag_in  = el_im(k, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        b0.in_valid = 1'b0;
        chk("pre_rst_wr_en", 32'(b0.bram_wr_en), 32'd1);
        chk("pre_rst_addr", 32'(b0.bram_wr_addr), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_wr_en", 32'(b0.bram_wr_en), 32'd0);
        chk("midrst_addr", 32'(b0.bram_wr_addr), 32'd0);
        chk("midrst_real", 32'(b0.bram_wr_real), 32'd0);
        chk("midrst_imag", 32'(b0.bram_wr_imag), 32'd0);
        chk("midrst_busy", 32'(b0.busy), 32'd0);
        chk("midrst_in_ready", 32'(b0.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(b0.busy), 32'd0);
        do_start(1'b0);
        stream(1'b0, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
